// File: rtl/avaliador_sequencia_param.sv
// Sequence-check datapath for one round of the note game, parametrised in buttons, depth and scoring.
// Optional REPETE_NOTA_EN: a wrong press or a timeout retries the same note instead of advancing.
module avaliador_sequencia_param #(
  parameter int N_BOTOES = 7,
  parameter int DEPTH    = 16,
  parameter int PTS_W    = 8,
  parameter int ERR_W    = 4,
  parameter int JANELA   = 500,
  parameter int BONUS    = 4,
  parameter int PENAL    = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                iniciar,
  input  logic [ADDR_W:0]     comprimento,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] nota_esperada,
  output logic [ADDR_W-1:0]   endereco,
  output logic                ativo,
  output logic                acerto,
  output logic                erro,
  output logic                timeout,
  output logic                fim_rodada,
  output logic [PTS_W-1:0]    pontos,
  output logic [ERR_W-1:0]    erros,
  output logic [2:0]          db_estado
);

  localparam int TMR_W = $clog2(JANELA);
  localparam logic [PTS_W-1:0] PTS_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LIBERA  = 3'd1,
    ESPERA  = 3'd2,
    COMPARA = 3'd3,
    AVANCA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t             estado;
  logic [N_BOTOES-1:0] b_meta, b_s, b_ant, b_lat;
  logic [TMR_W-1:0]    timer;
  logic [ADDR_W:0]     len;
  logic                evento, coincide, ultima;

  function automatic logic [PTS_W-1:0] soma_sat(input logic [PTS_W-1:0] p);
    longint s;
    s = longint'(p) + longint'(BONUS);
    if (s > longint'(PTS_MAX)) return PTS_MAX;
    return PTS_W'(s);
  endfunction

  function automatic logic [PTS_W-1:0] subtrai_piso(input logic [PTS_W-1:0] p);
    if (longint'(p) < longint'(PENAL)) return '0;
    return PTS_W'(longint'(p) - longint'(PENAL));
  endfunction

  function automatic logic [ERR_W-1:0] inc_sat(input logic [ERR_W-1:0] e);
    return (e == ERR_MAX) ? e : e + ERR_W'(1);
  endfunction

  function automatic logic um_bit(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

  assign evento    = (b_s != '0) && (b_ant == '0);
  assign coincide  = (b_lat == nota_esperada) && um_bit(b_lat);
  // The DEPTH-1 guard keeps endereco in range even if comprimento exceeds DEPTH.
  assign ultima    = ({1'b0, endereco} == len - (ADDR_W+1)'(1)) ||
                     (endereco == ADDR_W'(DEPTH-1));
  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= OCIOSO;
      b_meta     <= '0;
      b_s        <= '0;
      b_ant      <= '0;
      b_lat      <= '0;
      timer      <= '0;
      len        <= '0;
      endereco   <= '0;
      ativo      <= 1'b0;
      acerto     <= 1'b0;
      erro       <= 1'b0;
      timeout    <= 1'b0;
      fim_rodada <= 1'b0;
      pontos     <= '0;
      erros      <= '0;
    end else begin
      b_meta     <= botoes;
      b_s        <= b_meta;
      b_ant      <= b_s;
      acerto     <= 1'b0;
      erro       <= 1'b0;
      timeout    <= 1'b0;
      fim_rodada <= 1'b0;
      case (estado)
        OCIOSO: if (iniciar) begin
          if (comprimento == '0) begin
            fim_rodada <= 1'b1;
            estado     <= FIM;
          end else begin
            len      <= comprimento;
            endereco <= '0;
            erros    <= '0;
            ativo    <= 1'b1;
            estado   <= LIBERA;
          end
        end
        LIBERA: if (b_s == '0) begin
          timer  <= '0;
          estado <= ESPERA;
        end
        ESPERA: begin
          timer <= timer + TMR_W'(1);
          if (evento) begin
            b_lat  <= b_s;
            estado <= COMPARA;
          end else if (timer == TMR_W'(JANELA-1)) begin
            timeout <= 1'b1;
            erros   <= inc_sat(erros);
            pontos  <= subtrai_piso(pontos);
            estado  <= AVANCA;
          end
        end
        COMPARA: begin
          if (coincide) begin
            acerto <= 1'b1;
            pontos <= soma_sat(pontos);
          end else begin
            erro   <= 1'b1;
            erros  <= inc_sat(erros);
            pontos <= subtrai_piso(pontos);
          end
          estado <= AVANCA;
        end
        // acerto is still high here exactly when the note just compared was a hit.
        AVANCA: begin
`ifdef REPETE_NOTA_EN
          if (!acerto) begin
            if (erros == ERR_MAX) begin
              fim_rodada <= 1'b1;
              ativo      <= 1'b0;
              estado     <= FIM;
            end else begin
              estado <= LIBERA;
            end
          end else if (ultima) begin
`else
          if (ultima) begin
`endif
            fim_rodada <= 1'b1;
            ativo      <= 1'b0;
            estado     <= FIM;
          end else begin
            endereco <= endereco + ADDR_W'(1);
            estado   <= LIBERA;
          end
        end
        FIM:     estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_avaliador_sequencia_param.sv
// Bench for avaliador_sequencia_param: vector table, directed corner sequences and random rounds
// checked against a note-level scoring model.
module tb_avaliador_sequencia_param;

  localparam int JANELA = 500;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       iniciar;
  logic [4:0] comprimento;
  logic [6:0] botoes;
  logic [6:0] nota_esperada;
  logic [3:0] endereco;
  logic       ativo, acerto, erro, timeout, fim_rodada;
  logic [7:0] pontos;
  logic [3:0] erros;
  logic [2:0] db_estado;

  avaliador_sequencia_param dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .comprimento(comprimento),
    .botoes(botoes), .nota_esperada(nota_esperada), .endereco(endereco), .ativo(ativo),
    .acerto(acerto), .erro(erro), .timeout(timeout), .fim_rodada(fim_rodada),
    .pontos(pontos), .erros(erros), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [6:0] song [16];
  always @(posedge clock) nota_esperada <= song[endereco];

  int checks = 0;
  int errors = 0;
  int mp = 0;
  int me = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && (acerto || erro || timeout)) begin
      checks++;
      if (int'(acerto) + int'(erro) + int'(timeout) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: acerto=%0b erro=%0b timeout=%0b", acerto, erro, timeout);
      end
    end
  end

  function automatic int expect_kind(input logic [6:0] nota, input logic [6:0] press, input bit tmo);
    if (tmo) return 2;
    if (press == nota && $countones(press) == 1) return 0;
    return 1;
  endfunction

  function automatic void model_apply(input int kind);
    if (kind == 0) mp = (mp + 4 > 255) ? 255 : mp + 4;
    else begin
      me = (me + 1 > 15) ? 15 : me + 1;
      mp = (mp - 1 < 0) ? 0 : mp - 1;
    end
  endfunction

  task automatic start_round(input int len);
    @(negedge clock);
    comprimento = 5'(len);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    chk("ativo_start", longint'(ativo), 1);
  endtask

  // kind: 0 hit, 1 wrong, 2 timeout, 3 nothing; lat counts negedges from first ESPERA cycle.
  task automatic play(input logic [6:0] press, input bit tmo, input int d, input int exp_addr,
                      input bit hold, output int kind, output int lat);
    bit seen = 0;
    kind = 3;
    lat = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (db_estado == 3'd2) seen = 1;
    end
    chk("reach_espera", longint'(seen), 1);
    if (!seen) return;
    chk("endereco", longint'(endereco), exp_addr);
    for (int i = 0; i < JANELA + 20 && kind == 3; i++) begin
      if (!tmo && i == d) botoes = press;
      @(negedge clock);
      lat++;
      if (acerto) kind = 0;
      else if (erro) kind = 1;
      else if (timeout) kind = 2;
    end
    if (!hold) botoes = '0;
  endtask

  task automatic wait_fim();
    int n = 0;
    bit found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clock);
      n++;
      if (fim_rodada) found = 1;
    end
    chk("fim_latency", found ? n : -1, 1);
    chk("ativo_after_fim", longint'(ativo), 0);
    chk("erros_after_fim", longint'(erros), me);
  endtask

  // mode 0: random actions, 1: all hits, 2: all wrong presses
  task automatic run_round(input int len, input int mode);
    int addr = 0;
    bit done = 0;
    int kind, lat, ek, d, r;
    logic [6:0] nota, press;
    bit tmo;
    start_round(len);
    me = 0;
    while (!done) begin
      nota = 7'(1 << $urandom_range(6));
      song[addr] = nota;
      tmo = 0;
      d = $urandom_range(5);
      press = nota;
      if (mode == 2) press = {nota[5:0], nota[6]};
      else if (mode == 0) begin
        r = $urandom_range(9);
        if (r >= 5 && r < 7) press = {nota[5:0], nota[6]};
        else if (r >= 7 && r < 9) press = nota | 7'($urandom_range(127));
        else if (r == 9) tmo = 1;
      end
      ek = expect_kind(nota, press, tmo);
      play(press, tmo, d, addr, 0, kind, lat);
      chk("rnd_kind", kind, ek);
      chk("rnd_latency", lat, tmo ? JANELA : d + 4);
      model_apply(ek);
      chk("rnd_pontos", longint'(pontos), mp);
      chk("rnd_erros", longint'(erros), me);
`ifdef REPETE_NOTA_EN
      if (ek != 0) done = (me == 15);
      else if (addr == len - 1) done = 1;
      else addr++;
`else
      if (addr == len - 1) done = 1;
      else addr++;
`endif
    end
    wait_fim();
  endtask

  typedef struct {
    int         len;
    logic [6:0] nota;
    logic [6:0] press;
    bit         tmo;
    int         kind;
    int         pts;
    int         errs;
    bit         last;
  } vec_t;

  vec_t tab [6];

  initial begin
    int kind, lat, addr;
    bit flag;
    logic [6:0] nota;
    tab[0] = '{3, 7'b0000001, 7'b0000001, 0, 0, 4,  0, 0};
    tab[1] = '{0, 7'b0000010, 7'b0000010, 0, 0, 8,  0, 0};
    tab[2] = '{0, 7'b0000100, 7'b0000100, 0, 0, 12, 0, 1};
    tab[3] = '{2, 7'b0001000, 7'b0010000, 0, 1, 11, 1, 0};
    tab[4] = '{0, 7'b0100000, 7'b0000000, 1, 2, 10, 2, 1};
    tab[5] = '{1, 7'b0000001, 7'b0000011, 0, 1, 9,  1, 1};
    for (int i = 0; i < 16; i++) song[i] = '0;
    reset_n = 1'b0;
    iniciar = 1'b0;
    comprimento = '0;
    botoes = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_estado", longint'(db_estado), 0);
    chk("rst_outputs", longint'({endereco, ativo, acerto, erro, timeout, fim_rodada, pontos, erros}), 0);
    @(negedge clock);
    reset_n = 1'b1;

`ifndef REPETE_NOTA_EN
    addr = 0;
    for (int i = 0; i < 6; i++) begin
      if (tab[i].len != 0) begin
        start_round(tab[i].len);
        addr = 0;
      end
      song[addr] = tab[i].nota;
      play(tab[i].press, tab[i].tmo, 1, addr, 0, kind, lat);
      chk("tab_kind", kind, tab[i].kind);
      chk("tab_latency", lat, tab[i].tmo ? JANELA : 5);
      chk("tab_pontos", longint'(pontos), tab[i].pts);
      chk("tab_erros", longint'(erros), tab[i].errs);
      mp = tab[i].pts;
      me = tab[i].errs;
      if (tab[i].last) wait_fim();
      addr++;
    end
`endif

    // Held button: no second event until it is released and pressed again.
    start_round(2);
    me = 0;
    song[0] = 7'b0010000;
    play(7'b0010000, 0, 2, 0, 1, kind, lat);
    chk("hold_kind", kind, 0);
    model_apply(0);
    flag = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (acerto || erro || timeout) flag = 1;
    end
    chk("hold_no_pulse", longint'(flag), 0);
    chk("hold_in_libera", longint'(db_estado), 1);
    botoes = '0;
    song[1] = 7'b0010000;
    play(7'b0010000, 0, 0, 1, 0, kind, lat);
    chk("hold_second_kind", kind, 0);
    model_apply(0);
    chk("hold_pontos", longint'(pontos), mp);
    wait_fim();

    // Press arriving in the timer's final cycle wins over the timeout.
    start_round(1);
    me = 0;
    song[0] = 7'b0000100;
    play(7'b0000100, 0, JANELA - 3, 0, 0, kind, lat);
    chk("prio_kind", kind, 0);
    chk("prio_latency", lat, JANELA + 1);
    model_apply(0);
    chk("prio_pontos", longint'(pontos), mp);
    wait_fim();

    // Zero-length round.
    @(negedge clock);
    comprimento = '0;
    iniciar = 1'b1;
    flag = 0;
    kind = -1;
    for (int i = 1; i <= 3 && kind < 0; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      if (ativo) flag = 1;
      if (fim_rodada) kind = i;
    end
    chk("len0_fim_latency", kind, 1);
    chk("len0_ativo_never", longint'(flag), 0);
    chk("len0_pontos", longint'(pontos), mp);

    for (int i = 0; i < 6; i++) run_round($urandom_range(1, 16), 0);

    for (int i = 0; i < 5; i++) run_round(16, 1);
    chk("pontos_saturated", longint'(pontos), 255);
    run_round(16, 2);
    chk("erros_saturated", longint'(erros), 15);

    // Reset in the middle of ESPERA at address 2.
    start_round(4);
    me = 0;
    for (int i = 0; i < 2; i++) begin
      song[i] = 7'b1000000;
      play(7'b1000000, 0, 1, i, 0, kind, lat);
      chk("mid_kind", kind, 0);
    end
    flag = 0;
    for (int i = 0; i < 60 && !flag; i++) begin
      @(negedge clock);
      if (db_estado == 3'd2) flag = 1;
    end
    chk("mid_reach_espera", longint'(flag), 1);
    chk("mid_endereco", longint'(endereco), 2);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_estado", longint'(db_estado), 0);
    chk("mid_rst_outputs", longint'({endereco, ativo, acerto, erro, timeout, fim_rodada, pontos, erros}), 0);
    flag = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (fim_rodada) flag = 1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (fim_rodada) flag = 1;
    end
    chk("mid_no_fim", longint'(flag), 0);
    mp = 0;
    me = 0;

    run_round(1, 2);
    chk("penalty_floor", longint'(pontos), 0);

`ifdef REPETE_NOTA_EN
    start_round(3);
    me = 0;
    nota = 7'b0000010;
    for (int i = 0; i < 3; i++) song[i] = nota;
    play(nota, 0, 0, 0, 0, kind, lat);
    chk("rep_hit0", kind, 0);
    model_apply(0);
    play(7'b0000001, 0, 0, 1, 0, kind, lat);
    chk("rep_wrong", kind, 1);
    model_apply(1);
    play(nota, 0, 0, 1, 0, kind, lat);
    chk("rep_retry_hit", kind, 0);
    model_apply(0);
    play(nota, 0, 0, 2, 0, kind, lat);
    chk("rep_hit2", kind, 0);
    model_apply(0);
    chk("rep_pontos", longint'(pontos), mp);
    wait_fim();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
